tx_duc_fs4: RTL and testbench

- Parametrised fs/4 digital up-converter for the TX chain. Sits after the two I/Q delta-sigma modulators, replacing the fixed single-mode DUC.
- Adds an input FIFO with a valid/ready handshake, so the slower DDSM sample stream no longer needs phase alignment to the DUC.
- Adds a run-time selectable mixing mode: +fs/4, -fs/4 (spectral inversion), baseband pass, or mute.
- Also adds a clock enable and a saturating underflow counter. Each I/Q pair is expanded into 4 output samples on the full-rate clock.

---
 rtl/tx_pkg.sv | 20 ++
 rtl/tx_sync_fifo.sv | 46 ++++
 rtl/tx_duc_fs4.sv | 127 ++++++++++++
 tb/tb_tx_duc_fs4.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the fs/4 TX up-converter: mixing modes, phase limit, width helper.
package tx_pkg;

  typedef enum logic [1:0] {
    TX_MODE_POS_FS4 = 2'b00,
    TX_MODE_NEG_FS4 = 2'b01,
    TX_MODE_BB      = 2'b10,
    TX_MODE_MUTE    = 2'b11
  } tx_mode_e;

  localparam logic [1:0] PH_LAST = 2'd3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is presented combinationally.
module tx_sync_fifo
  import tx_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  // A push is refused whenever full, even if a pop frees a slot at the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/tx_duc_fs4.sv
// fs/4 digital up-converter: buffers I/Q pairs and expands each into a 4-sample symbol.
module tx_duc_fs4
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned OUT_W  = DATA_W + 1,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              clr_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic [OUT_W-1:0]  out_duc,
  output logic              out_valid,
  output logic [1:0]        phase,
  output logic [CNT_W-1:0]  underflow_cnt
);

  logic [2*DATA_W-1:0] head;
  logic                full, empty, push, pop;
  logic [1:0]          phase_q;
  tx_mode_e            mode_q, cur_mode;
  logic [DATA_W-1:0]   hold_i, hold_q, cur_i, cur_q;
  logic [OUT_W-1:0]    ext_i, ext_q, sample;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = en && (phase_q == '0) && !empty;

  tx_sync_fifo #(
    .WIDTH(2 * DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata({in_i, in_q}),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // Phase 0 mixes straight from the FIFO head and live mode; later phases use the latched copies.
  always_comb begin
    cur_mode = mode_q;
    cur_i    = hold_i;
    cur_q    = hold_q;
    if (phase_q == '0) begin
      cur_mode = tx_mode_e'(mode);
      cur_i    = head[2*DATA_W-1:DATA_W];
      cur_q    = head[DATA_W-1:0];
    end
  end

  assign ext_i = {{(OUT_W-DATA_W){cur_i[DATA_W-1]}}, cur_i};
  assign ext_q = {{(OUT_W-DATA_W){cur_q[DATA_W-1]}}, cur_q};

  always_comb begin
    sample = '0;
    case (cur_mode)
      TX_MODE_POS_FS4:
        case (phase_q)
          2'd0:    sample = ext_i;
          2'd1:    sample = ext_q;
          2'd2:    sample = -ext_i;
          default: sample = -ext_q;
        endcase
      TX_MODE_NEG_FS4:
        case (phase_q)
          2'd0:    sample = ext_i;
          2'd1:    sample = -ext_q;
          2'd2:    sample = -ext_i;
          default: sample = ext_q;
        endcase
      TX_MODE_BB: sample = ext_i;
      default:    sample = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= '0;
      mode_q        <= TX_MODE_POS_FS4;
      hold_i        <= '0;
      hold_q        <= '0;
      out_duc       <= '0;
      out_valid     <= 1'b0;
      phase         <= '0;
      underflow_cnt <= '0;
    end else begin
      if (clr_cnt)
        underflow_cnt <= '0;
      else if (en && (phase_q == '0) && empty && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + 1'b1;

      if (!en) begin
        out_valid <= 1'b0;
      end else if (phase_q == '0) begin
        phase <= '0;
        if (!empty) begin
          hold_i    <= head[2*DATA_W-1:DATA_W];
          hold_q    <= head[DATA_W-1:0];
          mode_q    <= tx_mode_e'(mode);
          out_duc   <= sample;
          out_valid <= 1'b1;
          phase_q   <= 2'd1;
        end else begin
          out_duc   <= '0;
          out_valid <= 1'b0;
        end
      end else begin
        out_duc   <= sample;
        out_valid <= 1'b1;
        phase     <= phase_q;
        phase_q   <= (phase_q == PH_LAST) ? 2'd0 : phase_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_duc_fs4.sv
// Self-checking bench for tx_duc_fs4: directed scenarios plus a randomized scoreboard run.
module tb_tx_duc_fs4;

  logic        clk = 1'b0;
  logic        rst, en, clr_cnt, in_valid;
  logic [1:0]  mode;
  logic [5:0]  in_i, in_q;
  logic        in_ready, out_valid;
  logic [6:0]  out_duc;
  logic [1:0]  phase;
  logic [15:0] underflow_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int i; int q; } pair_t;

  tx_duc_fs4 #(.DATA_W(6), .OUT_W(7), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
    .out_duc(out_duc), .out_valid(out_valid), .phase(phase),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk = ~clk;

  // Output is Re{x * j^n} with x = I - jQ for +fs/4 and x = I + jQ for -fs/4.
  function automatic int ref_sample(int m, int i, int q, int n);
    int c, s;
    c = (n == 0) ? 1 : (n == 2) ? -1 : 0;
    s = (n == 1) ? 1 : (n == 3) ? -1 : 0;
    case (m)
      0:       return i * c + q * s;
      1:       return i * c - q * s;
      2:       return i;
      default: return 0;
    endcase
  endfunction

  function automatic int dut_val();
    return int'($signed(out_duc));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input int i, input int q);
    in_i = 6'(i);
    in_q = 6'(q);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b00; clr_cnt = 1'b0; in_valid = 1'b0;
    set_pair(0, 0);
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_duc !== 7'd0) begin n_err++; $display("FAIL rst_duc got %0d exp 0", dut_val()); end
    n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL rst_phase got %0d exp 0", phase); end
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", underflow_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    en = 1'b1;
    repeat (10) tick();
    n_cmp++; if (underflow_cnt !== 16'd10) begin n_err++; $display("FAIL idle_cnt got %0d exp 10", underflow_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_duc !== 7'd0) begin n_err++; $display("FAIL idle_duc got %0d exp 0", dut_val()); end
    n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL idle_phase got %0d exp 0", phase); end
  endtask

  task automatic run_symbol(input string tag, input int m, input int i, input int q,
                            input int e0, input int e1, input int e2, input int e3);
    int exp_s [4];
    exp_s = '{e0, e1, e2, e3};
    mode = 2'(m);
    set_pair(i, q);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_push_edge_valid got %b exp 0", tag, out_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid[%0d] got %b exp 1", tag, k, out_valid); end
      n_cmp++; if (int'(phase) !== k) begin n_err++; $display("FAIL %s_phase[%0d] got %0d exp %0d", tag, k, phase, k); end
      n_cmp++; if (dut_val() !== exp_s[k]) begin n_err++; $display("FAIL %s_duc[%0d] got %0d exp %0d", tag, k, dut_val(), exp_s[k]); end
    end
  endtask

  task automatic test_mode00();
    run_symbol("m00", 0, 5, -3, 5, -3, -5, 3);
    n_cmp++; if (underflow_cnt !== 16'd11) begin n_err++; $display("FAIL m00_cnt got %0d exp 11", underflow_cnt); end
  endtask

  task automatic test_mode01();
    run_symbol("m01", 1, -32, -32, -32, 32, 32, -32);
  endtask

  task automatic test_fill();
    pair_t pd [5];
    int e;
    do_reset();
    en = 1'b0; mode = 2'b00;
    for (int j = 0; j < 5; j++) begin
      pd[j].i = int'($urandom_range(63)) - 32;
      pd[j].q = int'($urandom_range(63)) - 32;
    end
    in_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      set_pair(pd[j].i, pd[j].q);
      n_cmp++; if (in_ready !== (j < 4)) begin n_err++; $display("FAIL fill_ready[%0d] got %b exp %b", j, in_ready, (j < 4)); end
      tick();
    end
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_after_pop got %b exp 1", in_ready); end
        in_valid = 1'b0;
      end
      e = ref_sample(0, pd[k/4].i, pd[k/4].q, k % 4);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid[%0d] got %b exp 1", k, out_valid); end
      n_cmp++; if (int'(phase) !== k % 4) begin n_err++; $display("FAIL fill_phase[%0d] got %0d exp %0d", k, phase, k % 4); end
      n_cmp++; if (dut_val() !== e) begin n_err++; $display("FAIL fill_duc[%0d] got %0d exp %0d", k, dut_val(), e); end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_drained_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_mode_switch();
    pair_t a, b;
    int e;
    do_reset();
    en = 1'b1; mode = 2'b00;
    a.i = 13; a.q = -7; b.i = -20; b.q = 9;
    set_pair(a.i, a.q);
    in_valid = 1'b1;
    tick();
    set_pair(b.i, b.q);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) in_valid = 1'b0;
      if (k == 2) mode = 2'b01;
      tick();
      e = (k < 4) ? ref_sample(0, a.i, a.q, k) : ref_sample(1, b.i, b.q, k - 4);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sw_valid[%0d] got %b exp 1", k, out_valid); end
      n_cmp++; if (dut_val() !== e) begin n_err++; $display("FAIL sw_duc[%0d] got %0d exp %0d", k, dut_val(), e); end
    end
  endtask

  task automatic test_random();
    pair_t sq[$];
    pair_t cur, p;
    int sym_ph, cur_mode, avail, ucnt, dmode, e;
    bit den, push_now;
    do_reset();
    sym_ph = 0; ucnt = 0; cur_mode = 0; cur.i = 0; cur.q = 0;
    for (int c = 0; c < 700; c++) begin
      if (c < 600) begin
        en = ($urandom_range(9) < 7);
        in_valid = $urandom_range(1) == 1;
      end else begin
        en = 1'b1;
        in_valid = 1'b0;
      end
      mode = 2'($urandom_range(3));
      p.i = int'($urandom_range(63)) - 32;
      p.q = int'($urandom_range(63)) - 32;
      set_pair(p.i, p.q);
      den = en; dmode = int'(mode); avail = sq.size();
      push_now = in_valid && in_ready;
      if (push_now) sq.push_back(p);
      tick();
      if (!den) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_dis_valid[%0d] got %b exp 0", c, out_valid); end
      end else if (sym_ph == 0) begin
        n_cmp++; if (out_valid !== (avail > 0)) begin n_err++; $display("FAIL rnd_start_valid[%0d] got %b exp %b", c, out_valid, (avail > 0)); end
        if (avail == 0) ucnt++;
        else if (out_valid === 1'b1) begin
          cur = sq.pop_front();
          cur_mode = dmode;
          e = ref_sample(cur_mode, cur.i, cur.q, 0);
          n_cmp++; if (phase !== 2'd0 || dut_val() !== e) begin n_err++; $display("FAIL rnd_ph0[%0d] got ph%0d %0d exp ph0 %0d", c, phase, dut_val(), e); end
          sym_ph = 1;
        end
      end else begin
        e = ref_sample(cur_mode, cur.i, cur.q, sym_ph);
        n_cmp++; if (out_valid !== 1'b1 || int'(phase) !== sym_ph || dut_val() !== e) begin
          n_err++; $display("FAIL rnd_sym[%0d] got v%b ph%0d %0d exp v1 ph%0d %0d", c, out_valid, phase, dut_val(), sym_ph, e);
        end
        sym_ph = (sym_ph + 1) % 4;
      end
    end
    n_cmp++; if (sq.size() != 0) begin n_err++; $display("FAIL rnd_leftover got %0d exp 0", sq.size()); end
    n_cmp++; if (int'(underflow_cnt) !== ucnt) begin n_err++; $display("FAIL rnd_cnt got %0d exp %0d", underflow_cnt, ucnt); end
  endtask

  task automatic test_saturate();
    en = 1'b1; in_valid = 1'b0;
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_err++; $display("FAIL sat_clr0 got %0d exp 0", underflow_cnt); end
    repeat (65535) tick();
    n_cmp++; if (underflow_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_full got %0d exp 65535", underflow_cnt); end
    tick();
    n_cmp++; if (underflow_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %0d exp 65535", underflow_cnt); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_err++; $display("FAIL sat_clr_wins got %0d exp 0", underflow_cnt); end
    tick();
    n_cmp++; if (underflow_cnt !== 16'd1) begin n_err++; $display("FAIL sat_restart got %0d exp 1", underflow_cnt); end
  endtask

  task automatic test_async_rst();
    en = 1'b1; mode = 2'b00;
    set_pair(5, -3);
    in_valid = 1'b1;
    tick();
    set_pair(7, 2);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (phase !== 2'd2 || dut_val() !== -5) begin n_err++; $display("FAIL arst_pre got ph%0d %0d exp ph2 -5", phase, dut_val()); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_duc !== 7'd0) begin n_err++; $display("FAIL arst_duc got %0d exp 0", dut_val()); end
    n_cmp++; if (phase !== 2'd0) begin n_err++; $display("FAIL arst_phase got %0d exp 0", phase); end
    n_cmp++; if (underflow_cnt !== 16'd0) begin n_err++; $display("FAIL arst_cnt got %0d exp 0", underflow_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b exp 1", in_ready); end
    #2;
    rst = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_flushed got %b exp 0", out_valid); end
    n_cmp++; if (underflow_cnt !== 16'd1) begin n_err++; $display("FAIL arst_cnt_after got %0d exp 1", underflow_cnt); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_mode00();
    test_mode01();
    test_fill();
    test_mode_switch();
    test_random();
    test_saturate();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
